// File: rtl/sd_lvs_pkg.sv
`default_nettype none
// sd_lvs_pkg -- shared state encoding, default parameters and counter sizing
// for the SD low-voltage-signalling identification sequencer (rev 1.0).
package sd_lvs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_PULSE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_SENSE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int         DEF_DAT_WIDTH      = 4;
  localparam logic [3:0] DEF_SENSE_MASK     = 4'b0100;
  localparam int         DEF_HOLD_CYCLES    = 1024;
  localparam int         DEF_PULSE_CYCLES   = 8;
  localparam int         DEF_FILTER_LEN     = 4;
  localparam int         DEF_TIMEOUT_CYCLES = 4096;

  function automatic int cnt_width(input int hold, input int pulse, input int timeout);
    int m;
    m = hold;
    if (pulse > m)   m = pulse;
    if (timeout > m) m = timeout;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_lvs_filter.sv
`default_nettype none
// sd_lvs_filter -- per-line saturating run counter; full reports that the
// count reaches FILTER_LEN with the sample taken at the coming edge (rev 1.0).
module sd_lvs_filter
  import sd_lvs_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic full
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [FW-1:0] cnt;
  logic [FW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en) begin
      if (!din)
        cnt_nxt = '0;
      else if (cnt != FW'(FILTER_LEN))
        cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

  // Looking at the next count lets the sequencer finish in the cycle the run completes.
  assign full = (cnt_nxt == FW'(FILTER_LEN));

endmodule
`default_nettype wire

// File: rtl/sd_lvs_ident.sv
`default_nettype none
// sd_lvs_ident -- drives CMD/DAT low, pulses sd_clk, then releases and filters
// the sensed DAT lines to identify a low-voltage card (rev 1.0).
module sd_lvs_ident
  import sd_lvs_pkg::*;
#(
  parameter int                   DAT_WIDTH      = DEF_DAT_WIDTH,
  parameter logic [DAT_WIDTH-1:0] SENSE_MASK     = DAT_WIDTH'(DEF_SENSE_MASK),
  parameter int                   HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int                   PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int                   FILTER_LEN     = DEF_FILTER_LEN,
  parameter int                   TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 ok,
  output logic [DAT_WIDTH-1:0] datSeen,
  output logic                 sd_clk,
  output logic                 sd_cmdOut,
  output logic                 sd_cmdOutEn,
  output logic [DAT_WIDTH-1:0] sd_datOut,
  output logic [DAT_WIDTH-1:0] sd_datOutEn,
  input  logic [DAT_WIDTH-1:0] sd_datIn
);

  localparam int CW = cnt_width(HOLD_CYCLES, PULSE_CYCLES, TIMEOUT_CYCLES);

  generate
    if (HOLD_CYCLES == 0 || PULSE_CYCLES == 0 || TIMEOUT_CYCLES == 0 || FILTER_LEN == 0) begin : g_bad_cycles
      $error("sd_lvs_ident: cycle parameters must be non-zero");
    end
    if (SENSE_MASK == '0) begin : g_bad_mask
      $error("sd_lvs_ident: SENSE_MASK must select at least one line");
    end
    if (FILTER_LEN > TIMEOUT_CYCLES) begin : g_bad_filter
      $error("sd_lvs_ident: FILTER_LEN exceeds TIMEOUT_CYCLES");
    end
  endgenerate

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [DAT_WIDTH-1:0] full;
  logic                 in_release;
  logic                 in_sense;
  logic                 all_full;

  assign in_release = (state == ST_RELEASE);
  assign in_sense   = (state == ST_SENSE);
  assign all_full   = &(full | ~SENSE_MASK);

  for (genvar i = 0; i < DAT_WIDTH; i++) begin : g_filter
    // Unmasked lines never enable or see data, so their counters stay at zero.
    sd_lvs_filter #(
      .FILTER_LEN (FILTER_LEN)
    ) u_filter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (in_release & SENSE_MASK[i]),
      .en    (in_sense & SENSE_MASK[i]),
      .din   (sd_datIn[i] & SENSE_MASK[i]),
      .full  (full[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ok          <= 1'b0;
      datSeen     <= '0;
      sd_clk      <= 1'b0;
      sd_cmdOut   <= 1'b0;
      sd_cmdOutEn <= 1'b0;
      sd_datOut   <= '0;
      sd_datOutEn <= '0;
    end else if (abort && state != ST_IDLE) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ok          <= 1'b0;
      datSeen     <= '0;
      sd_clk      <= 1'b0;
      sd_cmdOutEn <= 1'b0;
      sd_datOutEn <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_HOLD;
            cnt         <= CW'(HOLD_CYCLES - 1);
            busy        <= 1'b1;
            ok          <= 1'b0;
            datSeen     <= '0;
            sd_cmdOut   <= 1'b0;
            sd_datOut   <= '0;
            sd_cmdOutEn <= 1'b1;
            sd_datOutEn <= '1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            state  <= ST_PULSE;
            cnt    <= CW'(PULSE_CYCLES - 1);
            sd_clk <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            state       <= ST_RELEASE;
            cnt         <= '0;
            sd_clk      <= 1'b0;
            sd_datOutEn <= sd_datOutEn & ~SENSE_MASK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RELEASE: begin
          state <= ST_SENSE;
          cnt   <= CW'(TIMEOUT_CYCLES - 1);
        end
        ST_SENSE: begin
          // Success is tested first so it wins over an expiring timeout.
          if (all_full || cnt == '0) begin
            state       <= ST_DONE;
            cnt         <= '0;
            done        <= 1'b1;
            ok          <= all_full;
            datSeen     <= full & SENSE_MASK;
            sd_cmdOutEn <= 1'b0;
            sd_datOutEn <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_lvs_ident.sv
`default_nettype none
// tb_sd_lvs_ident -- directed sequence with a done-event scoreboard for the
// default instance (mask 0100) and a second instance with mask 0110.
module tb_sd_lvs_ident;

  typedef struct {
    int         lat;
    logic       ok;
    logic [3:0] seen;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_start, a_abort;
  logic [3:0] a_dat_in;
  logic       a_busy, a_done, a_ok, a_sd_clk, a_cmd_out, a_cmd_oe;
  logic [3:0] a_dat_seen, a_dat_out, a_dat_oe;

  logic       b_start, b_abort;
  logic [3:0] b_dat_in;
  logic       b_busy, b_done, b_ok, b_sd_clk, b_cmd_out, b_cmd_oe;
  logic [3:0] b_dat_seen, b_dat_out, b_dat_oe;

  sd_lvs_ident u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (a_start),
    .abort       (a_abort),
    .busy        (a_busy),
    .done        (a_done),
    .ok          (a_ok),
    .datSeen     (a_dat_seen),
    .sd_clk      (a_sd_clk),
    .sd_cmdOut   (a_cmd_out),
    .sd_cmdOutEn (a_cmd_oe),
    .sd_datOut   (a_dat_out),
    .sd_datOutEn (a_dat_oe),
    .sd_datIn    (a_dat_in)
  );

  sd_lvs_ident #(
    .SENSE_MASK (4'b0110)
  ) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (b_start),
    .abort       (b_abort),
    .busy        (b_busy),
    .done        (b_done),
    .ok          (b_ok),
    .datSeen     (b_dat_seen),
    .sd_clk      (b_sd_clk),
    .sd_cmdOut   (b_cmd_out),
    .sd_cmdOutEn (b_cmd_oe),
    .sd_datOut   (b_dat_out),
    .sd_datOutEn (b_dat_oe),
    .sd_datIn    (b_dat_in)
  );

  int   cyc = 0;
  int   a_st = 0;
  int   b_st = 0;
  int   passed = 0;
  int   total = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] a_pins();
    return 32'({a_sd_clk, a_cmd_out, a_cmd_oe, a_dat_out, a_dat_oe, a_busy, a_done, a_ok, a_dat_seen});
  endfunction

  // Wait (from a negedge) until edge n of a run has occurred; edge 1 samples start.
  task automatic wait_rel(input int st, input int n);
    while (cyc - st + 1 < n) @(negedge clk);
  endtask

  task automatic start_a(input logic push, input int lat, input logic ok, input logic [3:0] seen);
    exp_t e;
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    a_st = cyc;
    if (push) begin
      e.lat = lat; e.ok = ok; e.seen = seen;
      qa.push_back(e);
    end
  endtask

  task automatic start_b(input int lat, input logic ok, input logic [3:0] seen);
    exp_t e;
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    b_st = cyc;
    e.lat = lat; e.ok = ok; e.seen = seen;
    qb.push_back(e);
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (qa.size() != 0 && n < 7000) begin @(posedge clk); n++; end
    if (qa.size() != 0) begin
      check("a_done_timeout", 32'(qa.size()), 32'd0);
      qa.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done_b();
    int n = 0;
    while (qb.size() != 0 && n < 7000) begin @(posedge clk); n++; end
    if (qb.size() != 0) begin
      check("b_done_timeout", 32'(qb.size()), 32'd0);
      qb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (a_done) begin
      if (qa.size() == 0) begin
        check("a_unexpected_done", 32'(a_done), 32'd0);
      end else begin
        ea = qa.pop_front();
        check("a_done_latency", 32'(cyc - a_st + 1), 32'(ea.lat));
        check("a_ok", 32'(a_ok), 32'(ea.ok));
        check("a_dat_seen", 32'(a_dat_seen), 32'(ea.seen));
        check("a_oe_at_done", 32'({a_cmd_oe, a_dat_oe}), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (b_done) begin
      if (qb.size() == 0) begin
        check("b_unexpected_done", 32'(b_done), 32'd0);
      end else begin
        eb = qb.pop_front();
        check("b_done_latency", 32'(cyc - b_st + 1), 32'(eb.lat));
        check("b_ok", 32'(b_ok), 32'(eb.ok));
        check("b_dat_seen", 32'(b_dat_seen), 32'(eb.seen));
        check("b_oe_at_done", 32'({b_cmd_oe, b_dat_oe}), 32'd0);
      end
    end
  end

  initial begin
    logic [7:0] pattern;
    rst_n = 1'b0;
    a_start = 1'b0; a_abort = 1'b0; a_dat_in = 4'b0000;
    b_start = 1'b0; b_abort = 1'b0; b_dat_in = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset_outputs_a", a_pins(), 32'd0);
    check("reset_outputs_b", 32'({b_sd_clk, b_cmd_oe, b_dat_oe, b_busy, b_ok, b_dat_seen}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal identification: DAT2 high from the 3rd SENSE sample.
    start_a(1'b1, 1 + 1024 + 8 + 1 + 2 + 4, 1'b1, 4'b0100);
    check("hold_drive", 32'({a_busy, a_sd_clk, a_cmd_out, a_cmd_oe, a_dat_out, a_dat_oe}), 32'b1_0_0_1_0000_1111);
    wait_rel(a_st, 1024);
    check("hold_last_clk", 32'(a_sd_clk), 32'd0);
    wait_rel(a_st, 1025);
    check("pulse_first_clk", 32'(a_sd_clk), 32'd1);
    wait_rel(a_st, 1032);
    check("pulse_last_clk", 32'(a_sd_clk), 32'd1);
    wait_rel(a_st, 1033);
    check("release_pins", 32'({a_sd_clk, a_cmd_oe, a_dat_oe}), 32'b0_1_1011);
    wait_rel(a_st, 1036);
    a_dat_in = 4'b0100;
    wait_done_a();
    repeat (5) @(negedge clk);
    check("result_held", 32'({a_busy, a_ok, a_dat_seen}), 32'b0_1_0100);
    a_dat_in = 4'b0000;

    // Timeout with DAT2 held low; the new start also clears the held result.
    start_a(1'b1, 1 + 1024 + 8 + 1 + 4096, 1'b0, 4'b0000);
    check("start_clears_result", 32'({a_ok, a_dat_seen}), 32'd0);
    wait_done_a();

    // A single low sample restarts the run; only the final 4-high run completes it.
    pattern = 8'b1110_1111;
    start_a(1'b1, 1 + 1024 + 8 + 1 + 8, 1'b1, 4'b0100);
    for (int i = 0; i < 8; i++) begin
      wait_rel(a_st, 1034 + i);
      a_dat_in = {1'b0, pattern[7 - i], 2'b00};
    end
    wait_done_a();
    a_dat_in = 4'b0000;

    // Abort on the 5th PULSE cycle, no done expected afterwards.
    start_a(1'b0, 0, 1'b0, 4'b0000);
    wait_rel(a_st, 1029);
    check("pulse_before_abort", 32'(a_sd_clk), 32'd1);
    a_abort = 1'b1;
    @(negedge clk) a_abort = 1'b0;
    check("abort_pins", 32'({a_sd_clk, a_cmd_oe, a_dat_oe, a_busy, a_done, a_ok}), 32'd0);
    repeat (40) @(negedge clk);

    // Two sensed lines; the repeated start during HOLD must not restart the run.
    b_dat_in = 4'b0110;
    start_b(1 + 1024 + 8 + 1 + 4, 1'b1, 4'b0110);
    wait_rel(b_st, 10);
    b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    wait_rel(b_st, 1035);
    check("b_sense_oe", 32'({b_cmd_oe, b_dat_oe}), 32'b1_1001);
    wait_done_b();
    b_dat_in = 4'b0000;

    // Reset during SENSE releases everything at once, then a clean rerun.
    start_a(1'b0, 0, 1'b0, 4'b0000);
    wait_rel(a_st, 1036);
    check("in_sense_busy", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("sense_reset_pins", a_pins(), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    a_dat_in = 4'b0100;
    start_a(1'b1, 1 + 1024 + 8 + 1 + 4, 1'b1, 4'b0100);
    wait_done_a();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_lvs_ident.md
SD_LVS_IDENT -- requirements
Module: sd_lvs_ident

Interface
REQ-001 SHALL expose parameter DAT_WIDTH, default 4, meaning the number of SD DAT lines.
REQ-002 SHALL expose parameter SENSE_MASK, default 4'b0100, meaning the DAT lines released and sensed after the clock pulse.
REQ-003 SHALL expose parameter HOLD_CYCLES, default 1024, meaning the clk cycles CMD/DAT are held low before the pulse.
REQ-004 SHALL expose parameter PULSE_CYCLES, default 8, meaning the sd_clk high width in clk cycles.
REQ-005 SHALL expose parameter FILTER_LEN, default 4, meaning the consecutive high samples required per sensed line.
REQ-006 SHALL expose parameter TIMEOUT_CYCLES, default 4096, meaning the maximum SENSE duration.
REQ-007 SHALL have ports: clk in 1, the single clock; rst_n in 1, reset, synchronous and active-low.
REQ-008 SHALL have ports: start in 1, request; abort in 1, cancel; busy out 1; done out 1, one-cycle pulse; ok out 1, valid at done.
REQ-009 SHALL have ports: datSeen out DAT_WIDTH, the filtered-high status per line captured at done.
REQ-010 SHALL have ports: sd_clk out 1; sd_cmdOut out 1; sd_cmdOutEn out 1; sd_datOut out DAT_WIDTH; sd_datOutEn out DAT_WIDTH; sd_datIn in DAT_WIDTH, already registered by the I/O cell.

Function
REQ-011 SHALL implement the states IDLE, HOLD, PULSE, RELEASE, SENSE and DONE.
REQ-012 IDLE: start=1 SHALL cause HOLD on the next cycle. In that same cycle sd_cmdOut=0, sd_datOut=0, sd_cmdOutEn=1 and sd_datOutEn=all-ones SHALL be registered. busy SHALL be 1 in every state except IDLE.
REQ-013 HOLD SHALL last exactly HOLD_CYCLES cycles, then go to PULSE. sd_clk SHALL stay 0.
REQ-014 PULSE SHALL hold sd_clk=1 for exactly PULSE_CYCLES cycles, then go to RELEASE.
REQ-015 RELEASE SHALL last one cycle. It SHALL set sd_clk=0 and clear sd_datOutEn bits where SENSE_MASK=1; other enables SHALL remain 1. It SHALL clear the filter counters.
REQ-016 SENSE: each masked line's filter SHALL count consecutive sd_datIn=1 samples, saturating at FILTER_LEN. Any 0 sample SHALL reset that line's count to 0.
REQ-017 SENSE SHALL go to DONE with ok=1 in the first cycle in which all masked filters are at FILTER_LEN.
REQ-018 SENSE SHALL go to DONE with ok=0 after TIMEOUT_CYCLES cycles without success. If success and timeout coincide in the same cycle, success SHALL win.
REQ-019 DONE SHALL last one cycle. In it: done=1; ok and datSeen registered, with unmasked datSeen bits equal to 0; sd_cmdOutEn=0; sd_datOutEn=0; next state IDLE.
REQ-020 ok and datSeen SHALL hold their values until the next accepted start, which SHALL clear both.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 abort=1 in any non-IDLE state SHALL, on the next cycle: go to IDLE; set sd_clk=0; set all enables to 0; set done=0; set ok=0. abort SHALL take priority over start and over all state transitions.
REQ-023 The counter SHALL be sized $clog2 of max(HOLD_CYCLES, PULSE_CYCLES, TIMEOUT_CYCLES)+1 and SHALL reload on every state entry. Wrap-around is forbidden.
REQ-024 Elaboration SHALL fail if any cycle parameter is 0, if SENSE_MASK is 0, or if FILTER_LEN > TIMEOUT_CYCLES.

Reset
REQ-025 When rst_n=0 at a clk edge, the state SHALL be IDLE and all outputs SHALL be 0: sd_clk, sd_cmdOut, sd_cmdOutEn, sd_datOut, sd_datOutEn, busy, done, ok and datSeen. All counters and filters SHALL be 0.
REQ-026 Reset mid-sequence SHALL release all pins in the same edge and SHALL NOT produce a done pulse.

Structure
REQ-027 The state enum, the default parameter values and the counter-width function SHALL reside in shared package sd_lvs_pkg.
REQ-028 The per-line saturating filter SHALL be sub-module sd_lvs_filter, generated DAT_WIDTH times. Unmasked instances SHALL be tied idle.

Verification
REQ-029 Defaults; start, with DAT2 driven high from the 3rd SENSE cycle: done SHALL pulse after 1+1024+8+1+2+4 cycles with ok=1 and datSeen=4'b0100.
REQ-030 Defaults; DAT2 held 0: done SHALL pulse after 4096 SENSE cycles with ok=0, datSeen=0 and all enables 0.
REQ-031 Defaults; DAT2 toggles 1,1,1,0,1,1,1,1: ok SHALL assert only after the final 4-high run, and never earlier.
REQ-032 abort on the 5th PULSE cycle: the next cycle SHALL show sd_clk=0, all enables 0 and busy=0, with no done pulse.
REQ-033 SENSE_MASK=4'b0110; start pulsed again during HOLD; DAT1 high and DAT2 high: the second start SHALL be ignored, ok=1, datSeen=4'b0110, and the DAT0/DAT3 enables SHALL stay 1 until DONE.
REQ-034 rst_n=0 for one cycle during SENSE: all outputs SHALL be 0 on the next cycle, and a subsequent start SHALL complete normally.
